ds_sample_scheduler: RTL and testbench

//  Feeds input samples to delta_sigma_pw_modulator at a programmable rate.

---
 rtl/ds_sample_scheduler_if.sv | 11 +
 rtl/ds_sample_scheduler.sv | 139 +++++++++++++
 tb/tb_ds_sample_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ds_sample_scheduler_if.sv
// Sample write stream into the scheduler FIFO: valid/ready handshake.
interface ds_sample_scheduler_if #(
    parameter int IN_BITS = 16
);
    logic               in_valid;
    logic [IN_BITS-1:0] in_data;
    logic               in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/ds_sample_scheduler.sv
// Sample scheduler for the delta-sigma PW modulator: FIFO-buffered samples,
// held for (hold_count+1) PWM periods each, with IDLE/PRIME/RUN start-up.
module ds_sample_scheduler #(
    parameter int IN_BITS     = 16,
    parameter int FIFO_AW     = 2,
    parameter int HOLD_BITS   = 8,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    ds_sample_scheduler_if.slave smp,
    input  logic [HOLD_BITS-1:0] hold_count,
    input  logic                 underrun_mute,
    input  logic                 pulse_done,
    output logic [IN_BITS-1:0]   u,
    output logic                 reset_lfsr,
    output logic                 running,
    output logic [FIFO_AW:0]     fifo_level,
    output logic                 underrun,
    input  logic                 underrun_clear
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PRIME_LVL = PRIME_LEVEL[FIFO_AW:0];

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    state_t state;

    logic [IN_BITS-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [HOLD_BITS-1:0] cnt;
    logic                 full, empty, wr, pop, flush;

    // Level never exceeds DEPTH, so its MSB alone marks full.
    assign full         = fifo_level[FIFO_AW];
    assign empty        = (fifo_level == '0);
    assign smp.in_ready = !full;
    assign wr           = smp.in_valid && !full;

    always_comb begin
        pop   = 1'b0;
        flush = 1'b0;
        case (state)
            PRIME: begin
                if (!enable)                      flush = 1'b1;
                else if (fifo_level >= PRIME_LVL) pop   = 1'b1;
            end
            RUN: begin
                if (!enable)                                     flush = 1'b1;
                else if (pulse_done && cnt == '0 && !empty)      pop   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= smp.in_data;
    end

    // A flush also discards any write accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({wr, pop})
                2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            u          <= '0;
            cnt        <= '0;
            reset_lfsr <= 1'b0;
            running    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            reset_lfsr <= 1'b0;
            underrun   <= underrun & ~underrun_clear;
            case (state)
                IDLE: begin
                    u       <= '0;
                    cnt     <= '0;
                    running <= 1'b0;
                    if (enable) begin
                        state      <= PRIME;
                        reset_lfsr <= 1'b1;
                    end
                end
                PRIME: begin
                    if (!enable) begin
                        state <= IDLE;
                        u     <= '0;
                        cnt   <= '0;
                    end else if (pop) begin
                        u       <= mem[rd_ptr];
                        cnt     <= hold_count;
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state   <= IDLE;
                        u       <= '0;
                        cnt     <= '0;
                        running <= 1'b0;
                    end else if (pulse_done) begin
                        if (cnt != '0) begin
                            cnt <= cnt - HOLD_BITS'(1);
                        end else begin
                            cnt <= hold_count;
                            if (!empty) begin
                                u <= mem[rd_ptr];
                            end else begin
                                underrun <= 1'b1;
                                if (underrun_mute) u <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    u       <= '0;
                    cnt     <= '0;
                    running <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ds_sample_scheduler.sv
// Bench for ds_sample_scheduler: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ds_sample_scheduler;
    logic        clk = 1'b0;
    logic        reset, enable, underrun_mute, pulse_done, underrun_clear;
    logic [7:0]  hold_count;
    logic [15:0] u;
    logic        reset_lfsr, running, underrun;
    logic [2:0]  fifo_level;

    ds_sample_scheduler_if #(.IN_BITS(16)) sif ();

    ds_sample_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable), .smp(sif),
        .hold_count(hold_count), .underrun_mute(underrun_mute),
        .pulse_done(pulse_done), .u(u), .reset_lfsr(reset_lfsr),
        .running(running), .fifo_level(fifo_level), .underrun(underrun),
        .underrun_clear(underrun_clear)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle, 1=prime, 2=run; FIFO as a queue.
    logic [15:0] q[$];
    int          ph;
    logic [15:0] m_u;
    bit          m_rl, m_und;
    int          m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            q.delete(); ph = 0; m_u = 0; m_rl = 0; m_und = 0; m_cnt = 0;
        end else begin
            automatic bit wr  = sif.in_valid && (q.size() < 4);
            automatic bit set = 0;
            automatic bit fl  = 0;
            m_rl = 0;
            if (ph == 0) begin
                m_u = 0; m_cnt = 0;
                if (enable) begin ph = 1; m_rl = 1; end
            end else if (!enable) begin
                fl = 1;
            end else if (ph == 1) begin
                if (q.size() >= 2) begin
                    m_u = q.pop_front(); m_cnt = int'(hold_count); ph = 2;
                end
            end else if (pulse_done) begin
                if (m_cnt > 0) m_cnt--;
                else begin
                    m_cnt = int'(hold_count);
                    if (q.size() > 0) m_u = q.pop_front();
                    else begin set = 1; if (underrun_mute) m_u = 0; end
                end
            end
            if (fl) begin
                q.delete(); ph = 0; m_u = 0; m_cnt = 0;
            end else if (wr) q.push_back(sif.in_data);
            m_und = set | (m_und & !underrun_clear);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_u",        32'(u),          32'(m_u));
            chk("model_level",    32'(fifo_level), 32'(q.size()));
            chk("model_in_ready", 32'(sif.in_ready), 32'(q.size() < 4));
            chk("model_running",  32'(running),    32'(ph == 2));
            chk("model_rst_lfsr", 32'(reset_lfsr), 32'(m_rl));
            chk("model_underrun", 32'(underrun),   32'(m_und));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        pulse_done = 1; tick(); pulse_done = 0; tick();
    endtask

    logic [15:0] exp_u [6];

    initial begin
        reset = 1; enable = 0; underrun_mute = 0; pulse_done = 0; underrun_clear = 0;
        hold_count = 8'd2; sif.in_valid = 0; sif.in_data = '0;
        tick(); chk_en = 1'b1; tick();
        reset = 0;
        chk("rst_u", 32'(u), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_in_ready", 32'(sif.in_ready), 32'h1);
        chk("rst_running", 32'(running), 32'h0);

        // Start-up: LFSR reset pulse, priming to two entries, first pop
        enable = 1; sif.in_valid = 1; sif.in_data = 16'h1111; tick();
        chk("t1_rst_lfsr_hi", 32'(reset_lfsr), 32'h1);
        sif.in_data = 16'h2222; tick();
        chk("t1_rst_lfsr_lo", 32'(reset_lfsr), 32'h0);
        chk("t1_not_running", 32'(running), 32'h0);
        sif.in_valid = 0; tick();
        chk("t1_running", 32'(running), 32'h1);
        chk("t1_u", 32'(u), 32'h1111);
        chk("t1_level", 32'(fifo_level), 32'h1);

        // hold_count=2: a new sample every third pulse
        sif.in_valid = 1; sif.in_data = 16'h3333; tick(); sif.in_valid = 0;
        chk("t2_level", 32'(fifo_level), 32'h2);
        exp_u = '{16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h2222, 16'h3333};
        for (int i = 0; i < 6; i++) begin
            pulse();
            chk($sformatf("t2_u_pulse%0d", i + 1), 32'(u), 32'(exp_u[i]));
        end

        // Underrun: counter drains from 2, then empty pop repeats u, then mutes
        hold_count = 8'd0;
        pulse(); pulse();
        chk("t4_no_underrun_yet", 32'(underrun), 32'h0);
        pulse();
        chk("t4_underrun", 32'(underrun), 32'h1);
        chk("t4_u_repeat", 32'(u), 32'h3333);
        underrun_mute = 1; pulse();
        chk("t4_u_muted", 32'(u), 32'h0);

        // Clear vs set in the same cycle, then clear alone
        underrun_clear = 1; pulse_done = 1; tick();
        chk("t5_set_wins", 32'(underrun), 32'h1);
        pulse_done = 0; tick();
        chk("t5_cleared", 32'(underrun), 32'h0);
        underrun_clear = 0; underrun_mute = 0;

        // enable drop with pulse_done and a same-cycle write: flush, no pop
        sif.in_valid = 1; sif.in_data = 16'hAAAA; tick();
        sif.in_data = 16'hBBBB; enable = 0; pulse_done = 1; tick();
        sif.in_valid = 0; pulse_done = 0;
        chk("t6_level", 32'(fifo_level), 32'h0);
        chk("t6_u", 32'(u), 32'h0);
        chk("t6_running", 32'(running), 32'h0);

        // Five back-to-back writes in IDLE: only four fit
        for (int i = 0; i < 5; i++) begin
            sif.in_valid = 1; sif.in_data = 16'h5001 + 16'(i);
            if (i == 4) chk("t3_full_ready", 32'(sif.in_ready), 32'h0);
            tick();
        end
        sif.in_valid = 0;
        chk("t3_level", 32'(fifo_level), 32'h4);

        // Run the buffered samples out until underrun, then reset mid-RUN
        hold_count = 8'd1; enable = 1; tick(); tick();
        chk("t3_first_pop", 32'(u), 32'h5001);
        pulse_done = 1;
        for (int i = 0; i < 10; i++) tick();
        pulse_done = 0;
        chk("t3_drained_u", 32'(u), 32'h5004);
        chk("t3_underrun", 32'(underrun), 32'h1);
        reset = 1; tick(); reset = 0;
        chk("t6_rst_u", 32'(u), 32'h0);
        chk("t6_rst_running", 32'(running), 32'h0);
        chk("t6_rst_underrun", 32'(underrun), 32'h0);
        chk("t6_rst_level", 32'(fifo_level), 32'h0);
        enable = 0; tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
